// File: rtl/pipeline_if_return_stage_if.sv
// Fetch-return bus: request/stall/flush in from fetch-prepare and control,
// ROM/DRAM read data in, registered instruction triple out to decode.
interface pipeline_if_return_stage_if;
    logic        stall;
    logic        flush;
    logic [63:0] pc_IFP;
    logic        if_channel_sel;
    logic [31:0] rom_rdata;
    logic [63:0] dram_rdata;
    logic        dram_rvalid;
    logic        fetch_busy;
    logic [31:0] inst_IF;
    logic [63:0] pc_IF;
    logic        inst_valid;

    modport master (
        output stall, flush, pc_IFP, if_channel_sel, rom_rdata, dram_rdata, dram_rvalid,
        input  fetch_busy, inst_IF, pc_IF, inst_valid
    );

    modport slave (
        input  stall, flush, pc_IFP, if_channel_sel, rom_rdata, dram_rdata, dram_rvalid,
        output fetch_busy, inst_IF, pc_IF, inst_valid
    );
endinterface

// File: rtl/pipeline_if_return_stage.sv
// Instruction-fetch return stage: pairs ROM/DRAM read data with its PC, one-entry stall buffer.
// Define IF_DRAM_FETCH_EN to build the variable-latency DRAM fetch channel.
module pipeline_if_return_stage (
    input  logic                        clk,
    input  logic                        reset,
    pipeline_if_return_stage_if.slave   bus
);
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

`ifdef IF_DRAM_FETCH_EN
    typedef enum logic [1:0] {IDLE, ROM_PEND, DRAM_PEND, DRAM_DROP} state_t;
`else
    typedef enum logic [1:0] {IDLE, ROM_PEND} state_t;
`endif

    state_t      state;
    logic [63:0] pend_pc;
    logic        hold_valid;
    logic [31:0] hold_inst;
    logic [63:0] hold_pc;
    logic        inst_valid_q;
    logic [31:0] inst_q;
    logic [63:0] pc_q;

    logic        busy;
    logic        accept;
    logic        resp_vld_p0;
    logic [31:0] resp_inst_p0;
    logic        unused_bits;

`ifdef IF_DRAM_FETCH_EN
    // Busy stays high through the rvalid cycle, so no accept can overlap a DRAM return.
    assign busy         = (state == DRAM_PEND) || (state == DRAM_DROP);
    assign resp_vld_p0  = (state == ROM_PEND) || ((state == DRAM_PEND) && bus.dram_rvalid);
    assign resp_inst_p0 = (state == DRAM_PEND) ? bus.dram_rdata[31:0] : bus.rom_rdata;
    assign unused_bits  = ^bus.dram_rdata[63:32];
`else
    assign busy         = 1'b0;
    assign resp_vld_p0  = (state == ROM_PEND);
    assign resp_inst_p0 = bus.rom_rdata;
    assign unused_bits  = ^{bus.if_channel_sel, bus.dram_rdata, bus.dram_rvalid};
`endif

    assign accept         = !bus.stall && !bus.flush && !busy;
    assign bus.fetch_busy = busy;
    assign bus.inst_IF    = inst_q;
    assign bus.pc_IF      = pc_q;
    assign bus.inst_valid = inst_valid_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            pend_pc      <= '0;
            hold_valid   <= 1'b0;
            hold_inst    <= NOP_INST;
            hold_pc      <= '0;
            inst_valid_q <= 1'b0;
            inst_q       <= NOP_INST;
            pc_q         <= '0;
        end else begin
            case (state)
`ifdef IF_DRAM_FETCH_EN
                DRAM_PEND: begin
                    if (bus.dram_rvalid)  state <= IDLE;
                    else if (bus.flush)   state <= DRAM_DROP;
                end
                DRAM_DROP: begin
                    if (bus.dram_rvalid)  state <= IDLE;
                end
`endif
                default: begin
                    if (!accept)                  state <= IDLE;
`ifdef IF_DRAM_FETCH_EN
                    else if (bus.if_channel_sel)  state <= DRAM_PEND;
`endif
                    else                          state <= ROM_PEND;
                end
            endcase

            if (accept) pend_pc <= bus.pc_IFP;

            // Decode-facing register: flush beats stall, drained hold beats new response.
            if (bus.flush) begin
                inst_valid_q <= 1'b0;
                inst_q       <= NOP_INST;
                hold_valid   <= 1'b0;
            end else if (bus.stall) begin
                if (resp_vld_p0) begin
                    hold_valid <= 1'b1;
                    hold_inst  <= resp_inst_p0;
                    hold_pc    <= pend_pc;
                end
            end else if (hold_valid) begin
                inst_valid_q <= 1'b1;
                inst_q       <= hold_inst;
                pc_q         <= hold_pc;
                hold_valid   <= 1'b0;
            end else if (resp_vld_p0) begin
                inst_valid_q <= 1'b1;
                inst_q       <= resp_inst_p0;
                pc_q         <= pend_pc;
            end else begin
                inst_valid_q <= 1'b0;
                inst_q       <= NOP_INST;
            end
        end
    end
endmodule

// File: tb/tb_pipeline_if_return_stage.sv
// Scoreboard bench for pipeline_if_return_stage; works with or without IF_DRAM_FETCH_EN.
module tb_pipeline_if_return_stage;
`ifdef IF_DRAM_FETCH_EN
    localparam bit DRAM_EN = 1'b1;
`else
    localparam bit DRAM_EN = 1'b0;
`endif
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pipeline_if_return_stage_if bus();

    pipeline_if_return_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t        sb_q[$];
    int          n_vec  = 0;
    int          n_miss = 0;
    bit          m_rom_pend, m_dram_out, m_dram_drop;
    logic [63:0] m_rom_pc, m_dram_pc;
    logic [31:0] prev_inst;
    logic [63:0] prev_pc;
    logic        prev_valid;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        sb_q.delete();
        m_rom_pend  = 1'b0;
        m_dram_out  = 1'b0;
        m_dram_drop = 1'b0;
    endtask

    task automatic check_reset_vals();
        check("rst_valid", 64'(bus.inst_valid), 64'd0);
        check("rst_inst",  64'(bus.inst_IF), 64'(NOP_INST));
        check("rst_pc",    bus.pc_IF, 64'd0);
        check("rst_busy",  64'(bus.fetch_busy), 64'd0);
    endtask

    // Called at a negedge; applies one cycle of stimulus and updates the expectation queue.
    task automatic drive(input logic st, input logic fl, input logic [63:0] pc, input logic sel,
                         input logic [31:0] rom, input logic [63:0] dd, input logic rv);
        bit acc;
        bus.stall = st;  bus.flush = fl;  bus.pc_IFP = pc;  bus.if_channel_sel = sel;
        bus.rom_rdata = rom;  bus.dram_rdata = dd;  bus.dram_rvalid = rv;
        #1;
        check("fetch_busy", 64'(bus.fetch_busy), 64'(DRAM_EN && m_dram_out));
        acc = !st && !fl && !(DRAM_EN && m_dram_out);
        @(posedge clk);
        if (m_rom_pend && !fl) sb_q.push_back('{pc: m_rom_pc, inst: rom});
        if (DRAM_EN && m_dram_out && rv) begin
            if (!m_dram_drop && !fl) sb_q.push_back('{pc: m_dram_pc, inst: dd[31:0]});
            m_dram_out = 1'b0;
        end else if (DRAM_EN && m_dram_out && fl) begin
            m_dram_drop = 1'b1;
        end
        if (fl) sb_q.delete();
        m_rom_pend = acc && !(DRAM_EN && sel);
        if (acc) begin
            m_rom_pc = pc;
            if (DRAM_EN && sel) begin
                m_dram_out  = 1'b1;
                m_dram_drop = 1'b0;
                m_dram_pc   = pc;
            end
        end
        @(negedge clk);
    endtask

    task automatic async_reset();
        #2 reset = 1'b1;
        #1 check_reset_vals();
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!reset) begin
            if (bus.flush) begin
                check("flush_valid", 64'(bus.inst_valid), 64'd0);
                check("flush_inst",  64'(bus.inst_IF), 64'(NOP_INST));
            end else if (bus.stall) begin
                check("stall_inst",  64'(bus.inst_IF), 64'(prev_inst));
                check("stall_pc",    bus.pc_IF, prev_pc);
                check("stall_valid", 64'(bus.inst_valid), 64'(prev_valid));
            end else if (bus.inst_valid && sb_q.size() == 0) begin
                check("unexpected_valid", 64'(bus.inst_valid), 64'd0);
            end else if (bus.inst_valid) begin
                e = sb_q.pop_front();
                check("inst", 64'(bus.inst_IF), 64'(e.inst));
                check("pc",   bus.pc_IF, e.pc);
            end else begin
                check("missing_inst", 64'(bus.inst_valid), 64'(sb_q.size() != 0));
                check("bubble_inst",  64'(bus.inst_IF), 64'(NOP_INST));
                check("bubble_pc",    bus.pc_IF, prev_pc);
            end
        end
        prev_inst  = bus.inst_IF;
        prev_pc    = bus.pc_IF;
        prev_valid = bus.inst_valid;
    end

    initial begin
        bus.stall = 1'b0;  bus.flush = 1'b0;  bus.pc_IFP = '0;  bus.if_channel_sel = 1'b0;
        bus.rom_rdata = '0;  bus.dram_rdata = '0;  bus.dram_rvalid = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_vals();
        reset = 1'b0;

        // ROM stream, then a response captured across a 2-cycle stall
        drive(0, 0, 64'h0,  0, 32'h0,          64'h0, 0);
        drive(0, 0, 64'h4,  0, 32'h0050_0093,  64'h0, 0);
        drive(0, 0, 64'h8,  0, 32'h00A0_0113,  64'h0, 0);
        drive(0, 0, 64'hC,  0, 32'h0020_81B3,  64'h0, 0);
        drive(0, 0, 64'h10, 0, 32'h00C0_0213,  64'h0, 0);
        drive(1, 0, 64'h14, 0, 32'h0100_0293,  64'h0, 0);
        drive(1, 0, 64'h14, 0, 32'hFFFF_FFFF,  64'h0, 0);
        drive(0, 0, 64'h14, 0, 32'hEEEE_EEEE,  64'h0, 0);
        drive(0, 0, 64'h18, 0, 32'h0140_0313,  64'h0, 0);

        // DRAM fetch with rvalid on the third busy cycle
        drive(0, 0, 64'h8000_0000, 1, 32'h0180_0393, 64'h0, 0);
        drive(0, 0, 64'h8000_0004, 0, 32'h1111_1111, 64'h0, 0);
        drive(0, 0, 64'h8000_0008, 0, 32'h2222_2222, 64'h0, 0);
        drive(0, 0, 64'h8000_000C, 0, 32'h3333_3333, 64'h0000_0000_0010_0073, 1);
        drive(0, 0, 64'h100, 0, 32'h4444_4444, 64'h0, 0);
        drive(0, 0, 64'h104, 0, 32'h0000_0033, 64'h0, 0);

        // Flush during DRAM_PEND, then the stale rvalid
        drive(0, 0, 64'h200, 1, 32'h0000_0133, 64'h0, 0);
        drive(0, 1, 64'h204, 0, 32'h5555_5555, 64'h0, 0);
        drive(0, 0, 64'h208, 0, 32'h6666_6666, 64'h0, 0);
        drive(0, 0, 64'h20C, 0, 32'h7777_7777, 64'h0000_0000_DEAD_BEEF, 1);
        drive(0, 0, 64'h300, 0, 32'h8888_8888, 64'h0, 0);
        drive(0, 0, 64'h304, 0, 32'h0010_0093, 64'h0, 0);

        // Flush coinciding with rvalid in DRAM_PEND
        drive(0, 0, 64'h280, 1, 32'h0020_0093, 64'h0, 0);
        drive(0, 0, 64'h284, 0, 32'h9999_9999, 64'h0, 0);
        drive(0, 1, 64'h288, 0, 32'hAAAA_AAAA, 64'h0000_0000_DEAD_BEEF, 1);
        drive(0, 0, 64'h28C, 0, 32'hBBBB_BBBB, 64'h0, 0);
        drive(0, 0, 64'h290, 0, 32'h0030_0093, 64'h0, 0);

        // Flush together with stall while the hold buffer is full
        drive(0, 0, 64'h400, 0, 32'h0040_0093, 64'h0, 0);
        drive(1, 0, 64'h404, 0, 32'h0050_0093, 64'h0, 0);
        drive(1, 1, 64'h404, 0, 32'hCCCC_CCCC, 64'h0, 0);
        drive(0, 0, 64'h404, 0, 32'hDDDD_DDDD, 64'h0, 0);
        drive(0, 0, 64'h408, 0, 32'h0060_0093, 64'h0, 0);

        // Async reset in the middle of a DRAM fetch, then a late rvalid
        drive(0, 0, 64'h8000_0100, 1, 32'h0070_0093, 64'h0, 0);
        drive(0, 0, 64'h8000_0104, 0, 32'h0000_0000, 64'h0, 0);
        async_reset();
        drive(0, 0, 64'h500, 0, 32'h0000_0000, 64'h0000_0000_0BAD_0BAD, 1);
        drive(0, 0, 64'h504, 0, 32'h0080_0093, 64'h0, 0);

        // Mixed random traffic
        for (int i = 0; i < 80; i++) begin
            drive(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 15) == 0),
                  {32'h0, $urandom & 32'hFFFF_FFFC}, 1'($urandom_range(0, 3) == 0),
                  $urandom, {$urandom, $urandom}, 1'($urandom_range(0, 2) == 0));
        end
        drive(0, 1, 64'h0, 0, 32'h0, 64'h0, 0);
        drive(0, 0, 64'h600, 0, 32'h0, 64'h0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/pipeline_if_return_stage.md
# pipeline_if_return_stage

Instruction-fetch return stage: the response side of the fetch-prepare stage. It captures the instruction word returning from the boot ROM or the DRAM channel, pairs it with the PC that requested it, and presents a registered instruction/PC/valid triple to decode. It absorbs pipeline stalls with a one-entry hold buffer, tracks outstanding variable-latency DRAM fetches, and discards wrong-path responses on branch flush.

## Interface
- NOP_INST, 32'h0000_0013: bubble encoding driven on `inst_IF` when not valid.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  pipeline stall; outputs to decode hold while high.
- flush  in  1  branch taken; kills fetched and in-flight instructions.
- pc_IFP  in  64  PC of the fetch being issued this cycle.
- if_channel_sel  in  1  channel of the fetch being issued: 0 = ROM, 1 = DRAM.
- rom_rdata  in  32  ROM read data; valid the cycle after the request is accepted.
- dram_rdata  in  64  DRAM read data; instruction in bits [31:0].
- dram_rvalid  in  1  single-cycle pulse qualifying `dram_rdata`.
- fetch_busy  out  1  DRAM fetch outstanding; upstream must freeze its PC.
- inst_IF  out  32  instruction to decode.
- pc_IF  out  64  PC of `inst_IF`.
- inst_valid  out  1  `inst_IF`/`pc_IF` hold a real instruction.

## Operation
- Request accepted in a cycle iff `!stall && !flush && !fetch_busy`; `pc_IFP` is latched as `pend_pc`.
- States: IDLE, ROM_PEND, DRAM_PEND, DRAM_DROP.
  - IDLE/ROM_PEND: on accept go to ROM_PEND (sel = 0) or DRAM_PEND (sel = 1), else go to IDLE.
  - DRAM_PEND: stay until `dram_rvalid`, then go to IDLE (no accept in that cycle, because `fetch_busy` is high).
  - DRAM_DROP: stay until `dram_rvalid`; that data is discarded; then go to IDLE.
- Response R = {pc = pend_pc, inst = rom_rdata} in ROM_PEND, or {pend_pc, dram_rdata[31:0]} in DRAM_PEND with `dram_rvalid`.
- Output register update, in priority order:
  - flush: `inst_valid <= 0`, `inst_IF <= NOP_INST`; hold buffer cleared; ROM_PEND goes to IDLE with its response dropped; DRAM_PEND goes to DRAM_DROP.
  - stall: outputs hold. If R is present, it is captured in the hold buffer (`hold_valid <= 1`).
  - otherwise, if `hold_valid`: outputs <= hold, `hold_valid <= 0`. Else if R: outputs <= R, `inst_valid <= 1`. Else bubble: `inst_valid <= 0`, `inst_IF <= NOP_INST`, `pc_IF` holds.
- The hold buffer is never occupied while a response arrives unstalled. No request is accepted during stall, so at most one response is ever buffered.
- `fetch_busy` is combinational: high in DRAM_PEND and DRAM_DROP, including the `dram_rvalid` cycle.
- `dram_rvalid` in IDLE or ROM_PEND is ignored.

## Timing
- Reset (async): state IDLE, `hold_valid` 0, `inst_valid` 0, `inst_IF` NOP_INST, `pc_IF` 0, `fetch_busy` 0.
- ROM: request accepted at edge N; instruction on `inst_IF` after edge N+1 (one-cycle latency, full throughput).
- DRAM: instruction on `inst_IF` after the edge where `dram_rvalid` is sampled. At most one DRAM fetch is outstanding.
- Stall release with `hold_valid`: held instruction appears after the first unstalled edge. A ROM request accepted in that same cycle follows one cycle later, with no gap.
- flush together with stall: flush wins. Flush together with `dram_rvalid` in DRAM_PEND: data is dropped and the state goes to IDLE.
- Reset mid-DRAM fetch: a later `dram_rvalid` in IDLE is ignored.

## Configuration
- `IF_DRAM_FETCH_EN` defined: DRAM channel as specified above.
- Not defined: `if_channel_sel`, `dram_rdata` and `dram_rvalid` are ignored. Every accept goes to ROM_PEND, DRAM_PEND and DRAM_DROP are not built, and `fetch_busy` is tied to 0.

## Test plan
- ROM stream: accept PCs 0, 4, 8 with rom_rdata 0x00500093, 0x00A00113, 0x002081B3 -> `inst_IF`/`pc_IF` match one cycle later each, `inst_valid` = 1 continuously.
- DRAM fetch: sel = 1, pc 0x8000_0000, `dram_rvalid` 3 cycles later with `dram_rdata` 0x0000_0000_0010_0073 -> `fetch_busy` high for 3 cycles; then `inst_IF` = 0x00100073, `pc_IF` = 0x8000_0000; bubbles (NOP, valid 0) in between.
- Stall capture: ROM response for pc 0x10 arrives while stall is high for 2 cycles -> outputs unchanged during stall, pc 0x10 presented after release.
- Flush during DRAM_PEND: flush, then `dram_rvalid` with 0xDEADBEEF -> never presented. `inst_valid` = 0 until the next accepted ROM fetch returns.
- Flush with stall and a full hold buffer -> hold cleared, `inst_valid` = 0, `inst_IF` = 0x00000013.
- Async reset asserted mid-DRAM fetch -> all outputs at reset values immediately; a subsequent `dram_rvalid` has no effect.
